// File: rtl/conv_encoder.sv
// Frame-based convolutional encoder. Reads info bits (LSB first) from a byte
// SRAM, encodes with up to six generator polynomials of memory m = 3..6 and
// writes one 24-bit softbit word per trellis step into a word SRAM, using the
// same word format the Viterbi decoder consumes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start_i; config validated and latched on accept
// PRELOAD | tail-biting only: read last m info bits into the shift reg
// ENCODE  | one info-bit read per cycle, indices 0..L-1
// FLUSH   | zero-tail only: m zero-input steps
// DONE    | pipeline draining; pulses frame_done_o after the last write

module conv_encoder #(
  parameter int SRC_ADDR_W = 12,
  parameter int DST_ADDR_W = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_an_i,
  input  logic                  rst_sync_i,
  input  logic                  start_i,
  input  logic [1:0]            register_num_i,
  input  logic [2:0]            valid_polynomials_i,
  input  logic                  tail_biting_en_i,
  input  logic [7:0]            polynomial1_i,
  input  logic [7:0]            polynomial2_i,
  input  logic [7:0]            polynomial3_i,
  input  logic [7:0]            polynomial4_i,
  input  logic [7:0]            polynomial5_i,
  input  logic [7:0]            polynomial6_i,
  input  logic [9:0]            infobit_length_i,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  err_o,
  output logic                  src_rd_o,
  output logic [SRC_ADDR_W-1:0] src_addr_o,
  input  logic [7:0]            src_rdata_i,
  output logic                  dst_wr_o,
  output logic [DST_ADDR_W-1:0] dst_addr_o,
  output logic [23:0]           dst_wdata_o
);

  typedef enum logic [2:0] {IDLE, PRELOAD, ENCODE, FLUSH, DONE} state_t;

  // step kinds travelling down the read pipeline
  localparam logic [1:0] K_PRE   = 2'd0;
  localparam logic [1:0] K_ENC   = 2'd1;
  localparam logic [1:0] K_FLUSH = 2'd2;

  state_t          state;
  logic [9:0]      idx;
  logic [2:0]      flush_cnt;

  logic [2:0]      m_q;
  logic [2:0]      n_q;
  logic            tb_q;
  logic [9:0]      len_q;
  logic [7:0]      poly_q [6];

  // stage A: read issued (src_rd_o cycle); stage B: read data present
  logic            a_valid;
  logic [2:0]      a_sel;
  logic [1:0]      a_kind;
  logic            b_valid;
  logic [2:0]      b_sel;
  logic [1:0]      b_kind;

  logic [5:0]      shift_q;
  logic [DST_ADDR_W-1:0] wr_cnt;

  logic [2:0]      m_in;
  logic [2:0]      n_in;
  logic            start_bad;
  logic            accept;

  logic [5:0]      s_mask;
  logic [7:0]      tap_mask;
  logic            u_b;
  logic [7:0]      tap_v;
  logic [5:0]      shift_nx;
  logic [23:0]     word_nx;

  // decode and validate the unlatched config presented with start_i
  always_comb begin
    m_in      = 3'd6 - {1'b0, register_num_i};
    n_in      = (valid_polynomials_i > 3'd4) ? 3'd6 : valid_polynomials_i + 3'd2;
    start_bad = (infobit_length_i == 10'd0) ||
                (tail_biting_en_i && (infobit_length_i < 10'(m_in)));
    accept    = (state == IDLE) && start_i && !start_bad;
  end

  // one encoder step: taps above m are masked off, shift reg kept at m bits
  always_comb begin
    s_mask   = '0;
    tap_mask = '0;
    for (int i = 0; i < 6; i++) s_mask[i] = (3'(i) < m_q);
    for (int i = 0; i < 7; i++) tap_mask[i] = (3'(i) <= m_q);
    u_b      = (b_kind == K_FLUSH) ? 1'b0 : src_rdata_i[b_sel];
    tap_v    = {1'b0, shift_q, u_b} & tap_mask;
    shift_nx = {shift_q[4:0], u_b} & s_mask;
    word_nx  = '0;
    for (int k = 0; k < 6; k++) begin
      if (3'(k) < n_q) word_nx[4*k +: 4] = (^(poly_q[k] & tap_v)) ? 4'h9 : 4'h7;
    end
  end

  // frame sequencer: config latch, read issue and status pulses
  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      state <= IDLE; idx <= '0; flush_cnt <= '0;
      m_q <= '0; n_q <= '0; tb_q <= 1'b0; len_q <= '0;
      for (int k = 0; k < 6; k++) poly_q[k] <= '0;
      a_valid <= 1'b0; a_sel <= '0; a_kind <= K_PRE;
      busy_o <= 1'b0; frame_done_o <= 1'b0; err_o <= 1'b0;
      src_rd_o <= 1'b0; src_addr_o <= '0;
    end else if (rst_sync_i) begin
      state <= IDLE; idx <= '0; flush_cnt <= '0;
      m_q <= '0; n_q <= '0; tb_q <= 1'b0; len_q <= '0;
      for (int k = 0; k < 6; k++) poly_q[k] <= '0;
      a_valid <= 1'b0; a_sel <= '0; a_kind <= K_PRE;
      busy_o <= 1'b0; frame_done_o <= 1'b0; err_o <= 1'b0;
      src_rd_o <= 1'b0; src_addr_o <= '0;
    end else begin
      err_o        <= 1'b0;
      frame_done_o <= 1'b0;
      src_rd_o     <= 1'b0;
      a_valid      <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (start_bad) begin
              err_o <= 1'b1;
            end else begin
              m_q       <= m_in;
              n_q       <= n_in;
              tb_q      <= tail_biting_en_i;
              len_q     <= infobit_length_i;
              poly_q[0] <= polynomial1_i;
              poly_q[1] <= polynomial2_i;
              poly_q[2] <= polynomial3_i;
              poly_q[3] <= polynomial4_i;
              poly_q[4] <= polynomial5_i;
              poly_q[5] <= polynomial6_i;
              busy_o    <= 1'b1;
              if (tail_biting_en_i) begin
                state <= PRELOAD;
                idx   <= infobit_length_i - 10'(m_in);
              end else begin
                state <= ENCODE;
                idx   <= '0;
              end
            end
          end
        end
        PRELOAD: begin
          src_rd_o   <= 1'b1;
          src_addr_o <= SRC_ADDR_W'(idx[9:3]);
          a_valid    <= 1'b1;
          a_sel      <= idx[2:0];
          a_kind     <= K_PRE;
          if (idx == len_q - 10'd1) begin
            state <= ENCODE;
            idx   <= '0;
          end else begin
            idx <= idx + 10'd1;
          end
        end
        ENCODE: begin
          src_rd_o   <= 1'b1;
          src_addr_o <= SRC_ADDR_W'(idx[9:3]);
          a_valid    <= 1'b1;
          a_sel      <= idx[2:0];
          a_kind     <= K_ENC;
          if (idx == len_q - 10'd1) begin
            state     <= tb_q ? DONE : FLUSH;
            flush_cnt <= '0;
          end else begin
            idx <= idx + 10'd1;
          end
        end
        FLUSH: begin
          a_valid   <= 1'b1;
          a_sel     <= '0;
          a_kind    <= K_FLUSH;
          flush_cnt <= flush_cnt + 3'd1;
          if (flush_cnt == m_q - 3'd1) state <= DONE;
        end
        DONE: begin
          // last write is on the bus and nothing is left in flight
          if (dst_wr_o && !a_valid && !b_valid) begin
            frame_done_o <= 1'b1;
            busy_o       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // data stage: shift register update and registered word write
  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      b_valid <= 1'b0; b_sel <= '0; b_kind <= K_PRE;
      shift_q <= '0; wr_cnt <= '0;
      dst_wr_o <= 1'b0; dst_addr_o <= '0; dst_wdata_o <= '0;
    end else if (rst_sync_i) begin
      b_valid <= 1'b0; b_sel <= '0; b_kind <= K_PRE;
      shift_q <= '0; wr_cnt <= '0;
      dst_wr_o <= 1'b0; dst_addr_o <= '0; dst_wdata_o <= '0;
    end else begin
      b_valid  <= a_valid;
      b_sel    <= a_sel;
      b_kind   <= a_kind;
      dst_wr_o <= 1'b0;
      if (accept) begin
        shift_q    <= '0;
        wr_cnt     <= '0;
        dst_addr_o <= '0;
      end else if (b_valid) begin
        shift_q <= shift_nx;
        if (b_kind != K_PRE) begin
          dst_wr_o    <= 1'b1;
          dst_wdata_o <= word_nx;
          dst_addr_o  <= wr_cnt;
          wr_cnt      <= wr_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder with a byte source SRAM model and a write log.
module tb_conv_encoder;

  logic        clk = 1'b0;
  logic        rst_an_i = 1'b0;
  logic        rst_sync_i = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  register_num_i = '0;
  logic [2:0]  valid_polynomials_i = '0;
  logic        tail_biting_en_i = 1'b0;
  logic [7:0]  p1 = '0, p2 = '0, p3 = '0, p4 = '0, p5 = '0, p6 = '0;
  logic [9:0]  infobit_length_i = '0;
  logic        busy_o, frame_done_o, err_o, src_rd_o, dst_wr_o;
  logic [11:0] src_addr_o, dst_addr_o;
  logic [7:0]  src_rdata_i = '0;
  logic [23:0] dst_wdata_o;

  logic [7:0]  mem [0:255];
  logic [23:0] wr_data [$];
  int          wr_addr [$];
  int          rd_cnt = 0, done_cnt = 0, cyc = 0, last_wr_cyc = -1;
  int          n_cmp = 0, n_err = 0;

  conv_encoder #(.SRC_ADDR_W(12), .DST_ADDR_W(12)) dut (
    .clk_i(clk), .rst_an_i(rst_an_i), .rst_sync_i(rst_sync_i), .start_i(start_i),
    .register_num_i(register_num_i), .valid_polynomials_i(valid_polynomials_i),
    .tail_biting_en_i(tail_biting_en_i),
    .polynomial1_i(p1), .polynomial2_i(p2), .polynomial3_i(p3),
    .polynomial4_i(p4), .polynomial5_i(p5), .polynomial6_i(p6),
    .infobit_length_i(infobit_length_i), .busy_o(busy_o), .frame_done_o(frame_done_o),
    .err_o(err_o), .src_rd_o(src_rd_o), .src_addr_o(src_addr_o), .src_rdata_i(src_rdata_i),
    .dst_wr_o(dst_wr_o), .dst_addr_o(dst_addr_o), .dst_wdata_o(dst_wdata_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // source SRAM: data valid the cycle after the read strobe
  always @(posedge clk) if (src_rd_o) src_rdata_i <= mem[src_addr_o[7:0]];

  // write/read/done log sampled mid-cycle
  always @(negedge clk) begin
    if (dst_wr_o) begin
      wr_data.push_back(dst_wdata_o);
      wr_addr.push_back(int'(dst_addr_o));
      last_wr_cyc = cyc;
    end
    if (src_rd_o) rd_cnt++;
    if (frame_done_o) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [1:0] rn, input logic [2:0] vp, input logic tb,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d, input logic [7:0] e, input logic [7:0] f,
                         input logic [9:0] len);
    register_num_i = rn; valid_polynomials_i = vp; tail_biting_en_i = tb;
    p1 = a; p2 = b; p3 = c; p4 = d; p5 = e; p6 = f; infobit_length_i = len;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic clear_log();
    wr_data.delete(); wr_addr.delete(); rd_cnt = 0;
  endtask

  // waits for frame_done_o, then checks its timing and that it is one cycle wide
  task automatic wait_done(input string tag, input int max);
    int k = 0;
    while (frame_done_o !== 1'b1 && k < max) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_seen"}, 32'(k < max), 32'd1);
    chk({tag, "_done_after_last_wr"}, 32'(last_wr_cyc), 32'(cyc - 1));
    chk({tag, "_busy_low_at_done"}, 32'(busy_o), 32'd0);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(frame_done_o), 32'd0);
  endtask

  task automatic check_writes(input string tag, input logic [23:0] exp[$]);
    chk({tag, "_wr_count"}, 32'(wr_data.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < wr_data.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), 32'(i));
      chk($sformatf("%s_data%0d", tag, i), 32'(wr_data[i]), 32'(exp[i]));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ctl"}, 32'({busy_o, frame_done_o, err_o, src_rd_o, dst_wr_o}), 32'd0);
    chk({tag, "_addrs"}, 32'({src_addr_o, dst_addr_o}), 32'd0);
    chk({tag, "_wdata"}, 32'(dst_wdata_o), 32'd0);
  endtask

  logic [23:0] exp_tail[$]  = '{24'h99, 24'h99, 24'h79, 24'h99, 24'h79, 24'h79, 24'h99};
  logic [23:0] exp_tbite[$] = '{24'h97, 24'h97, 24'h97, 24'h99};
  logic [23:0] exp_r6[$]    = '{24'h999999, 24'h777777, 24'h999999, 24'h777777,
                                24'h777777, 24'h999999, 24'h777777, 24'h999999,
                                24'h777777, 24'h777777, 24'h777777, 24'h777777,
                                24'h777777, 24'h777777};

  initial begin
    int done_before, bad;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // reset state
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_an_i = 1'b1;
    @(negedge clk);

    // zero-tail, m=3, rate 1/2, with a mid-frame start and config change
    mem[0] = 8'h0D;
    set_cfg(2'd3, 3'd0, 1'b0, 8'h0B, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 10'd4);
    clear_log();
    pulse_start();
    chk("t1_busy_after_start", 32'(busy_o), 32'd1);
    @(negedge clk);
    set_cfg(2'd0, 3'd4, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 10'd0);
    pulse_start();
    chk("t1_midframe_no_err", 32'(err_o), 32'd0);
    wait_done("t1", 50);
    check_writes("t1", exp_tail);
    chk("t1_reads", 32'(rd_cnt), 32'd4);

    // tail-biting, same code
    set_cfg(2'd3, 3'd0, 1'b1, 8'h0B, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 10'd4);
    clear_log();
    pulse_start();
    wait_done("t2", 50);
    check_writes("t2", exp_tbite);
    chk("t2_reads", 32'(rd_cnt), 32'd7);
    chk("t2_final_state", 32'(dut.shift_q), 32'h03);

    // rate 1/6, m=6, identity polynomials
    mem[0] = 8'hA5;
    set_cfg(2'd0, 3'd4, 1'b0, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 10'd8);
    clear_log();
    pulse_start();
    wait_done("t3", 60);
    check_writes("t3", exp_r6);

    // rejection: L=0
    set_cfg(2'd3, 3'd0, 1'b0, 8'h0B, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 10'd0);
    clear_log();
    pulse_start();
    chk("rej_l0_err", 32'(err_o), 32'd1);
    chk("rej_l0_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    chk("rej_l0_err_pulse", 32'(err_o), 32'd0);
    repeat (4) @(negedge clk);
    chk("rej_l0_no_traffic", 32'(rd_cnt + wr_data.size()), 32'd0);
    chk("rej_l0_still_idle", 32'(busy_o), 32'd0);

    // rejection: tail-biting with L < m
    set_cfg(2'd0, 3'd0, 1'b1, 8'h0B, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 10'd5);
    pulse_start();
    chk("rej_short_tb_err", 32'(err_o), 32'd1);
    chk("rej_short_tb_busy", 32'(busy_o), 32'd0);
    @(negedge clk);

    // async reset in the middle of an L=100 frame
    mem[0] = 8'h00;
    set_cfg(2'd3, 3'd0, 1'b0, 8'h0B, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 10'd100);
    clear_log();
    pulse_start();
    repeat (20) @(negedge clk);
    chk("arst_was_writing", 32'({busy_o, dst_wr_o}), 32'd3);
    done_before = done_cnt;
    #2 rst_an_i = 1'b0;
    #1 check_idle_outputs("arst_now");
    @(negedge clk);
    rst_an_i = 1'b1;
    clear_log();
    repeat (6) @(negedge clk);
    chk("arst_no_traffic", 32'(rd_cnt + wr_data.size()), 32'd0);
    chk("arst_no_done", 32'(done_cnt), 32'(done_before));

    // full L=100 frame after the abort: all-zero input gives all +7 words
    clear_log();
    pulse_start();
    wait_done("t4", 300);
    chk("t4_wr_count", 32'(wr_data.size()), 32'd103);
    bad = 0;
    foreach (wr_data[i]) if (wr_data[i] !== 24'h77 || wr_addr[i] != i) bad++;
    chk("t4_bad_words", 32'(bad), 32'd0);

    // synchronous reset aborts a frame
    clear_log();
    pulse_start();
    repeat (5) @(negedge clk);
    done_before = done_cnt;
    rst_sync_i = 1'b1;
    @(negedge clk);
    rst_sync_i = 1'b0;
    check_idle_outputs("srst");
    repeat (6) @(negedge clk);
    chk("srst_no_done", 32'(done_cnt), 32'(done_before));

    // back-to-back frames, second start in the cycle after frame_done_o
    mem[0] = 8'h0D;
    set_cfg(2'd3, 3'd0, 1'b0, 8'h0B, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 10'd4);
    clear_log();
    pulse_start();
    begin
      int k = 0;
      while (frame_done_o !== 1'b1 && k < 50) begin
        @(negedge clk);
        k++;
      end
      chk("b2b_first_done", 32'(k < 50), 32'd1);
    end
    clear_log();
    @(negedge clk);
    pulse_start();
    wait_done("b2b", 50);
    check_writes("b2b", exp_tail);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
